freq_divi_prog: RTL and testbench

FREQ_DIVI_PROG -- requirements
Module: freq_divi_prog

---
 rtl/freq_divi_pkg.sv | 12 +
 rtl/freq_divi_ch.sv | 127 ++++++++++++
 rtl/freq_divi_prog.sv | 42 ++++
 tb/tb_freq_divi_prog.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/freq_divi_pkg.sv
// Shared types and defaults for the programmable multi-channel clock divider.
package freq_divi_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_CH    = 2;

endpackage

// File: rtl/freq_divi_ch.sv
// One divider channel: glitch-free divisor changes at period boundaries.
// Optional tick output when FREQ_DIVI_PROG_TICK_EN is defined.
module freq_divi_ch
    import freq_divi_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    input  logic             load,
    output logic             out,
    output logic             pending,
    output logic             bad_cfg
`ifdef FREQ_DIVI_PROG_TICK_EN
    ,
    output logic             tick
`endif
);

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic [CNT_W:0]   ONE_X = (CNT_W+1)'(1);

    ch_state_e        r_state;
    logic [CNT_W-1:0] r_cur_div;
    logic [CNT_W-1:0] r_pend_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_pending;
    logic             r_bad_cfg;

    ch_state_e        w_nxt_state;
    logic [CNT_W-1:0] w_nxt_cur;
    logic [CNT_W-1:0] w_nxt_pend;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic             w_nxt_pending;
    logic             w_terminal;
    logic [CNT_W:0]   w_div_x;
    logic [CNT_W:0]   w_half;
    logic             w_nxt_out;

    assign w_terminal = (r_state == RUN) && (r_cnt == (r_cur_div - ONE));

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_cur     = r_cur_div;
        w_nxt_pend    = r_pend_div;
        w_nxt_pending = r_pending;
        w_nxt_cnt     = '0;
        if (r_state == IDLE) begin
            // Idle loads take effect immediately and discard any stale request.
            if (load) begin
                w_nxt_cur     = div;
                w_nxt_pending = 1'b0;
            end
            w_nxt_state = (en && (w_nxt_cur >= TWO)) ? RUN : IDLE;
        end else if (!en) begin
            w_nxt_state = IDLE;
            if (load) begin
                w_nxt_pend    = div;
                w_nxt_pending = 1'b1;
            end
        end else if (w_terminal) begin
            // A load on the boundary edge wins over an older pending value.
            if (load) begin
                w_nxt_cur     = div;
                w_nxt_pending = 1'b0;
            end else if (r_pending) begin
                w_nxt_cur     = r_pend_div;
                w_nxt_pending = 1'b0;
            end
            w_nxt_state = (w_nxt_cur >= TWO) ? RUN : IDLE;
        end else begin
            w_nxt_cnt = r_cnt + ONE;
            if (load) begin
                w_nxt_pend    = div;
                w_nxt_pending = 1'b1;
            end
        end
    end

    // High phase length is ceil(N/2); one extra bit keeps N = 2^CNT_W-1 safe.
    assign w_div_x   = {1'b0, w_nxt_cur};
    assign w_half    = (w_div_x + ONE_X) >> 1;
    assign w_nxt_out = (w_nxt_state == RUN) && ({1'b0, w_nxt_cnt} < w_half);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cur_div  <= TWO;
            r_pend_div <= '0;
            r_cnt      <= '0;
            r_out      <= 1'b0;
            r_pending  <= 1'b0;
            r_bad_cfg  <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_cur_div  <= w_nxt_cur;
            r_pend_div <= w_nxt_pend;
            r_cnt      <= w_nxt_cnt;
            r_out      <= w_nxt_out;
            r_pending  <= w_nxt_pending;
            r_bad_cfg  <= (w_nxt_cur < TWO);
        end
    end

    assign out     = r_out;
    assign pending = r_pending;
    assign bad_cfg = r_bad_cfg;

`ifdef FREQ_DIVI_PROG_TICK_EN
    logic r_tick;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= (w_nxt_state == RUN) && (w_nxt_cnt == '0);
        end
    end

    assign tick = r_tick;
`endif

endmodule

// File: rtl/freq_divi_prog.sv
// Programmable clock divider: CH independent channels of CNT_W-bit divisors.
// Define FREQ_DIVI_PROG_TICK_EN to add the per-channel period tick output.
module freq_divi_prog
    import freq_divi_pkg::*;
#(
    parameter int CH    = DEF_CH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                clock,
    input  logic                rst,
    input  logic [CH-1:0]       en,
    input  logic [CH*CNT_W-1:0] div,
    input  logic [CH-1:0]       load,
    output logic [CH-1:0]       out,
    output logic [CH-1:0]       pending,
    output logic [CH-1:0]       bad_cfg
`ifdef FREQ_DIVI_PROG_TICK_EN
    ,
    output logic [CH-1:0]       tick
`endif
);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        freq_divi_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clock   (clock),
            .rst     (rst),
            .en      (en[g]),
            .div     (div[g*CNT_W +: CNT_W]),
            .load    (load[g]),
            .out     (out[g]),
            .pending (pending[g]),
            .bad_cfg (bad_cfg[g])
`ifdef FREQ_DIVI_PROG_TICK_EN
            ,
            .tick    (tick[g])
`endif
        );
    end

endmodule

// File: tb/tb_freq_divi_prog.sv
// Directed bench for freq_divi_prog: vector table on channel 0 plus
// hand-written async reset, wide-divisor and tick sequences.
module tb_freq_divi_prog;

    localparam int CH    = 2;
    localparam int CNT_W = 16;

    logic                clock;
    logic                rst;
    logic [CH-1:0]       en;
    logic [CH*CNT_W-1:0] div;
    logic [CH-1:0]       load;
    logic [CH-1:0]       out;
    logic [CH-1:0]       pending;
    logic [CH-1:0]       bad_cfg;
`ifdef FREQ_DIVI_PROG_TICK_EN
    logic [CH-1:0]       tick;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    freq_divi_prog #(.CH(CH), .CNT_W(CNT_W)) dut (
        .clock   (clock),
        .rst     (rst),
        .en      (en),
        .div     (div),
        .load    (load),
        .out     (out),
        .pending (pending),
        .bad_cfg (bad_cfg)
`ifdef FREQ_DIVI_PROG_TICK_EN
        ,
        .tick    (tick)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] dv;
        logic [2:0]  exp;   // {out, pending, bad_cfg} of channel 0 after the edge
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic e, input logic l, input int d,
                       input logic o, input logic p, input logic b);
        vec_t v;
        v.en = e; v.ld = l; v.dv = 16'(d); v.exp = {o, p, b};
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int hi, lo, k, errs;
        string nm;

        // N=4 start from idle load
        add(1,1,4, 1,0,0); add(1,0,0, 1,0,0); add(1,0,0, 0,0,0); add(1,0,0, 0,0,0);
        add(1,0,0, 1,0,0); add(1,0,0, 1,0,0);
        // load 6 at cnt=1: pending until boundary, then 3/3
        add(1,1,6, 0,1,0); add(1,0,0, 0,1,0); add(1,0,0, 1,0,0); add(1,0,0, 1,0,0);
        add(1,0,0, 1,0,0); add(1,0,0, 0,0,0); add(1,0,0, 0,0,0); add(1,0,0, 0,0,0);
        add(1,0,0, 1,0,0);
        // two loads while pending: last one (5) wins
        add(1,1,3, 1,1,0); add(1,1,5, 1,1,0); add(1,0,0, 0,1,0); add(1,0,0, 0,1,0);
        add(1,0,0, 0,1,0); add(1,0,0, 1,0,0); add(1,0,0, 1,0,0); add(1,0,0, 1,0,0);
        add(1,0,0, 0,0,0); add(1,0,0, 0,0,0);
        // load coinciding with terminal edge -> N=3 directly, 2 high / 1 low
        add(1,1,3, 1,0,0); add(1,0,0, 1,0,0); add(1,0,0, 0,0,0); add(1,0,0, 1,0,0);
        add(1,0,0, 1,0,0); add(1,0,0, 0,0,0); add(1,0,0, 1,0,0);
        // en drops mid-period with a pending value retained
        add(1,1,4, 1,1,0); add(0,0,0, 0,1,0); add(0,0,0, 0,1,0); add(1,0,0, 1,1,0);
        add(1,0,0, 1,1,0); add(1,0,0, 0,1,0); add(1,0,0, 1,0,0); add(1,0,0, 1,0,0);
        add(1,0,0, 0,0,0);
        // divisor 1 then 0 -> bad_cfg, out held low; recover with N=2
        add(1,1,1, 0,1,0); add(1,0,0, 0,0,1); add(1,0,0, 0,0,1); add(1,1,0, 0,0,1);
        add(1,1,2, 1,0,0); add(1,0,0, 0,0,0); add(1,0,0, 1,0,0);
        // idle with en low, then idle load
        add(0,0,0, 0,0,0); add(0,1,3, 0,0,0);

        rst = 1'b0; en = '0; load = '0; div = '0;
        repeat (3) @(negedge clock);
        chk("reset_state", int'({out, pending, bad_cfg}), 0);
        rst = 1'b1;
        @(negedge clock);
        chk("post_reset_idle", int'({out, pending, bad_cfg}), 0);

        for (int i = 0; i < tv.size(); i++) begin
            en   = {1'b0, tv[i].en};
            load = {1'b0, tv[i].ld};
            div  = {16'd0, tv[i].dv};
            step();
            nm = $sformatf("vec%0d", i);
            chk(nm, int'({out[0], pending[0], bad_cfg[0]}), int'(tv[i].exp));
            chk({nm, "_ch1"}, int'({out[1], pending[1], bad_cfg[1]}), 0);
            @(negedge clock);
        end

        // Async reset mid-period with N=5 at cnt=2
        en = 2'b01; load = 2'b01; div = {16'd0, 16'd5};
        step(); @(negedge clock);
        load = '0;
        step(); step();
        chk("n5_cnt2_high", int'(out[0]), 1);
        @(negedge clock);
        rst = 1'b0;
        #1;
        chk("async_rst_out", int'(out[0]), 0);
        chk("async_rst_flags", int'({pending, bad_cfg}), 0);
        @(negedge clock);
        rst = 1'b1;
        step();
        chk("rst_release_first_edge", int'(out[0]), 1);
        step();
        chk("rst_release_n2_low", int'(out[0]), 0);
        @(negedge clock);

        // Simultaneous loads: ch0 N=2, ch1 N=65535
        rst = 1'b0; en = '0; load = '0;
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        en = 2'b11; load = 2'b11; div = {16'd65535, 16'd2};
        step();
        load = '0;
        hi = 0; lo = 0; k = 0; errs = 0;
        while (out[1] && hi < 70000) begin
            if (out[0] != ((k % 2) == 0)) errs++;
            hi++; k++;
            step();
        end
        while (!out[1] && lo < 70000) begin
            if (out[0] != ((k % 2) == 0)) errs++;
            lo++; k++;
            step();
        end
        chk("ch1_high_cycles", hi, 32768);
        chk("ch1_low_cycles", lo, 32767);
        chk("ch0_n2_pattern_errs", errs, 0);
        chk("wide_flags", int'({pending, bad_cfg}), 0);
        @(negedge clock);

`ifdef FREQ_DIVI_PROG_TICK_EN
        rst = 1'b0; en = '0; load = '0;
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        en = 2'b01; load = 2'b01; div = {16'd0, 16'd8};
        errs = 0;
        for (int e = 0; e < 24; e++) begin
            step();
            load = '0;
            if (tick[0] != ((e % 8) == 0)) errs++;
            if (out[0] != ((e % 8) < 4)) errs++;
        end
        chk("tick_n8_errs", errs, 0);
        @(negedge clock);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
